// File: rtl/display_code_encoder.sv
// Serial double-dabble formatter driving four 6-bit seven-segment symbol codes.
// Also emits blank, fixed four-letter messages and prefixed numbers.
module display_code_encoder #(
  parameter int VALUE_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [VALUE_W-1:0] value,
  input  logic [1:0]         msg_id,
  output logic               busy,
  output logic               done,
  output logic [5:0]         code3,
  output logic [5:0]         code2,
  output logic [5:0]         code1,
  output logic [5:0]         code0
);

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

  localparam logic [5:0] BL   = 6'd63;
  localparam logic [3:0] LAST = 4'(VALUE_W - 1);

  state_t             state, next;
  logic [1:0]         mode_q, id_q;
  logic [VALUE_W-1:0] bin;
  logic [15:0]        bcd, adj;
  logic [3:0]         cnt;
  logic [3:0]         th, hu, te, un;
  logic [5:0]         n3, n2, n1, n0;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // mode[0] set means a numeric request that needs conversion
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (start) next = mode[0] ? SHIFT : FORMAT;
      SHIFT:   if (cnt == LAST) next = FORMAT;
      FORMAT:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3
                                               : bcd[i*4 +: 4];
    end
  end

  assign th = bcd[15:12];
  assign hu = bcd[11:8];
  assign te = bcd[7:4];
  assign un = bcd[3:0];

  always_comb begin
    n3 = BL;
    n2 = BL;
    n1 = BL;
    n0 = BL;
    case (mode_q)
      2'b10: begin
        case (id_q)
          2'd0:    {n3, n2, n1, n0} = {6'd11, 6'd30, 6'd28, 6'd29};
          2'd1:    {n3, n2, n1, n0} = {6'd17, 6'd18, 6'd29, BL};
          2'd2:    {n3, n2, n1, n0} = {6'd28, 6'd29, 6'd10, 6'd34};
          default: {n3, n2, n1, n0} = {6'd25, 6'd30, 6'd28, 6'd17};
        endcase
      end
      2'b01: begin
        n3 = (th != 0) ? {2'b00, th} : BL;
        n2 = ((th | hu) != 0) ? {2'b00, hu} : BL;
        n1 = ((th | hu | te) != 0) ? {2'b00, te} : BL;
        n0 = {2'b00, un};
      end
      2'b11: begin
        n3 = id_q[0] ? 6'd13 : 6'd25;
        if (th != 0) begin
          {n2, n1, n0} = {6'd14, 6'd27, 6'd27};
        end else begin
          n2 = (hu != 0) ? {2'b00, hu} : BL;
          n1 = ((hu | te) != 0) ? {2'b00, te} : BL;
          n0 = {2'b00, un};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= '0;
      id_q   <= '0;
      bin    <= '0;
      bcd    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      code3  <= BL;
      code2  <= BL;
      code1  <= BL;
      code0  <= BL;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          mode_q <= mode;
          id_q   <= msg_id;
          bin    <= value;
          bcd    <= '0;
          cnt    <= '0;
        end
        SHIFT: begin
          {bcd, bin} <= {adj, bin} << 1;
          cnt        <= cnt + 4'd1;
        end
        FORMAT: begin
          code3 <= n3;
          code2 <= n2;
          code1 <= n1;
          code0 <= n0;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_code_encoder.sv
// Bench for display_code_encoder: two widths (6 and 11 bits) share stimulus,
// each checked every cycle against a decimal-arithmetic reference model.
module tb_display_code_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [10:0] value;
  logic [1:0]  msg_id;

  logic       busy6, done6, busy11, done11;
  logic [5:0] a3, a2, a1, a0, b3, b2, b1, b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  display_code_encoder #(.VALUE_W(6)) d6 (
    .clk(clk), .reset(rst), .start(start), .mode(mode),
    .value(value[5:0]), .msg_id(msg_id), .busy(busy6), .done(done6),
    .code3(a3), .code2(a2), .code1(a1), .code0(a0)
  );

  display_code_encoder #(.VALUE_W(11)) d11 (
    .clk(clk), .reset(rst), .start(start), .mode(mode),
    .value(value), .msg_id(msg_id), .busy(busy11), .done(done11),
    .code3(b3), .code2(b2), .code1(b1), .code0(b0)
  );

  wire [23:0] act6  = {a3, a2, a1, a0};
  wire [23:0] act11 = {b3, b2, b1, b0};

  function automatic logic [23:0] expect_codes(
    input logic [1:0] m, input int v, input logic [1:0] id);
    logic [5:0] c3, c2, c1, c0;
    int th, hu, te, un;
    th = v / 1000;
    hu = (v / 100) % 10;
    te = (v / 10) % 10;
    un = v % 10;
    c3 = 6'd63; c2 = 6'd63; c1 = 6'd63; c0 = 6'd63;
    case (m)
      2'd1: begin
        if (v >= 1000) c3 = 6'(th);
        if (v >= 100)  c2 = 6'(hu);
        if (v >= 10)   c1 = 6'(te);
        c0 = 6'(un);
      end
      2'd2: begin
        case (id)
          2'd0:    {c3, c2, c1, c0} = {6'd11, 6'd30, 6'd28, 6'd29};
          2'd1:    {c3, c2, c1, c0} = {6'd17, 6'd18, 6'd29, 6'd63};
          2'd2:    {c3, c2, c1, c0} = {6'd28, 6'd29, 6'd10, 6'd34};
          default: {c3, c2, c1, c0} = {6'd25, 6'd30, 6'd28, 6'd17};
        endcase
      end
      2'd3: begin
        c3 = id[0] ? 6'd13 : 6'd25;
        if (v >= 1000) begin
          {c2, c1, c0} = {6'd14, 6'd27, 6'd27};
        end else begin
          if (v >= 100) c2 = 6'(hu);
          if (v >= 10)  c1 = 6'(te);
          c0 = 6'(un);
        end
      end
      default: ;
    endcase
    return {c3, c2, c1, c0};
  endfunction

  // Reference: a request is a countdown of its latency, then a result drop.
  int          rem [2];
  logic [23:0] pend [2];
  logic [23:0] ecodes [2];
  logic        ebusy [2];
  logic        edone [2];
  int          mv;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rem[i]    = 0;
        ebusy[i]  = 1'b0;
        edone[i]  = 1'b0;
        ecodes[i] = {4{6'd63}};
      end else begin
        edone[i] = 1'b0;
        if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) begin
            ecodes[i] = pend[i];
            edone[i]  = 1'b1;
          end
        end else if (start) begin
          mv      = (i == 0) ? int'(value[5:0]) : int'(value);
          pend[i] = expect_codes(mode, mv, msg_id);
          rem[i]  = mode[0] ? ((i == 0) ? 7 : 12) : 1;
        end
        ebusy[i] = (rem[i] > 0);
      end
    end
  end

  task automatic chk(input string name, input logic [23:0] act,
                     input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy6", 24'(busy6), 24'(ebusy[0]));
    chk("done6", 24'(done6), 24'(edone[0]));
    chk("codes6", act6, ecodes[0]);
    chk("busy11", 24'(busy11), 24'(ebusy[1]));
    chk("done11", 24'(done11), 24'(edone[1]));
    chk("codes11", act11, ecodes[1]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] m, input int v, input logic [1:0] id);
    tick();
    mode = m; value = 11'(v); msg_id = id; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
  endtask

  task automatic lit(input string name, input logic [23:0] e6,
                     input logic [23:0] e11);
    chk({name, "_w6"}, act6, e6);
    chk({name, "_w11"}, act11, e11);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; value = '0; msg_id = 2'd0;
    repeat (3) tick();
    lit("reset", {4{6'd63}}, {4{6'd63}});
    rst = 1'b0;
    repeat (20) tick();

    req(2'd1, 21, 2'd0);
    lit("num21", {6'd63, 6'd63, 6'd2, 6'd1}, {6'd63, 6'd63, 6'd2, 6'd1});
    req(2'd1, 0, 2'd0);
    lit("num0", {6'd63, 6'd63, 6'd63, 6'd0}, {6'd63, 6'd63, 6'd63, 6'd0});
    req(2'd1, 63, 2'd0);
    lit("num63", {6'd63, 6'd63, 6'd6, 6'd3}, {6'd63, 6'd63, 6'd6, 6'd3});

    tick();
    mode = 2'd2; msg_id = 2'd2; start = 1'b1;
    tick();
    msg_id = 2'd0;
    tick();
    chk("msg_done", 24'(done6), 24'd1);
    lit("stay", {6'd28, 6'd29, 6'd10, 6'd34}, {6'd28, 6'd29, 6'd10, 6'd34});
    tick();
    start = 1'b0;
    tick();
    lit("bust", {6'd11, 6'd30, 6'd28, 6'd29}, {6'd11, 6'd30, 6'd28, 6'd29});

    req(2'd3, 17, 2'd1);
    lit("d17", {6'd13, 6'd63, 6'd1, 6'd7}, {6'd13, 6'd63, 6'd1, 6'd7});
    req(2'd3, 1005, 2'd0);
    lit("p1005", {6'd25, 6'd63, 6'd4, 6'd5}, {6'd25, 6'd14, 6'd27, 6'd27});
    req(2'd3, 250, 2'd0);
    lit("p250", {6'd25, 6'd63, 6'd5, 6'd8}, {6'd25, 6'd2, 6'd5, 6'd0});

    tick();
    mode = 2'd1; value = 11'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    mode = 2'd2; value = 11'd40; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    lit("busyprot", {6'd63, 6'd63, 6'd63, 6'd9}, {6'd63, 6'd63, 6'd63, 6'd9});

    tick();
    mode = 2'd1; value = 11'd21; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {22'd0, busy6, busy11}, 24'd0);
    chk("rst_done", {22'd0, done6, done11}, 24'd0);
    lit("rst_mid", {4{6'd63}}, {4{6'd63}});
    tick();
    rst = 1'b0;
    req(2'd1, 21, 2'd0);
    lit("after_rst", {6'd63, 6'd63, 6'd2, 6'd1}, {6'd63, 6'd63, 6'd2, 6'd1});

    tick();
    mode = 2'd2; msg_id = 2'd3; start = 1'b1;
    repeat (10) tick();
    start = 1'b0;
    repeat (3) tick();
    lit("push", {6'd25, 6'd30, 6'd28, 6'd17}, {6'd25, 6'd30, 6'd28, 6'd17});

    repeat (600) begin
      tick();
      start  = ($urandom_range(0, 2) == 0);
      mode   = 2'($urandom);
      value  = 11'($urandom);
      msg_id = 2'($urandom);
      rst    = ($urandom_range(0, 79) == 0);
    end
    rst = 1'b0; start = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
